seq_code_arbiter: RTL and testbench
===================================

# seq_code_arbiter

Round-robin arbiter that shares one 14-state scrambled 4-bit code sequence between NREQ requesters. Each grant hands the current code to exactly one requester and advances the sequence by one step. Consumers therefore receive unique, in-order tokens from a single sequence owner instead of each running a private counter. The block sits between the token consumers and the shared sequence state, which it holds internally.

## Interface
- NREQ, 4, number of requesters (legal 2..8)
- SEED, 8, code loaded on reset/clear; must be a member of the sequence
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous restart: sequence to SEED, pointer to 0, lap_cnt to 0
- hold  in  1  when 1, no grants issued; state frozen
- req  in  NREQ  per-requester token request, level-sensitive
- gnt  out  NREQ  one-hot (or zero) grant, combinational from req/hold/clear/ptr
- code  out  4  current sequence code (registered), valid to grantee when code_valid=1
- code_valid  out  1  OR of gnt
- wrap  out  1  code_valid && code==13 (last code of lap being issued)
- lap_cnt  out  8  number of completed laps, modulo 256

## Operation
- Sequence (next-code function): 8→7→11→4→9→2→5→12→6→3→15→1→14→13→8. Codes 0 and 10 are non-members; next of a non-member is 8.
- Grant: if reset, clear or hold is 1, or req==0, gnt=0. Otherwise gnt selects the first asserted req[i], searching i=ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
- On a rising edge with a grant to index g: seq <= next(seq); ptr <= (g+1) mod NREQ; if wrap, lap_cnt <= lap_cnt+1 (wraps 255→0).
- No grant: seq, ptr, lap_cnt hold.
- clear=1 (and reset=0): seq <= SEED, ptr <= 0, lap_cnt <= 0; no grant that cycle; clear wins over req and hold.
- hold=1, clear=0: everything frozen and gnt=0; req may stay asserted and is serviced once hold drops.
- Requester handshake: req[i]&gnt[i] at an edge consumes code. A requester holding req high receives one token per grant. Back-to-back grants every cycle occur for a lone requester. With several active requesters, grants rotate.
- A requester that drops req before being granted loses nothing: no state change is made on its behalf.

## Timing
- Reset values: code=SEED (8), ptr=0, lap_cnt=0, gnt=0, code_valid=0, wrap=0.
- Reset is asynchronous: assertion forces the above immediately, mid-grant included; the in-flight token is not consumed.
- Grant latency 0: gnt and code_valid are valid in the same cycle req is presented. code changes only on the edge after a grant.
- Throughput: 1 token/cycle aggregate; with k active requesters each is granted exactly once per k grants.
- Simultaneous clear+req: clear wins, gnt=0, no token issued. Simultaneous hold+req: gnt=0.
- wrap is combinational and coincides with the grant of code 13. lap_cnt increments on that edge.

## Test plan
- Reset: assert reset mid-stream (after 5 grants). Required: code=8, gnt=0, lap_cnt=0 immediately; the first grant after release issues 8.
- Single requester, req[0]=1 for 15 cycles: codes 8,7,11,4,9,2,5,12,6,3,15,1,14,13,8. wrap=1 only on the 14th grant. lap_cnt=1 after it.
- All four requesting continuously from reset: gnt order 0001,0010,0100,1000,0001 with codes 8,7,11,4,9. Each requester is served once per 4 cycles.
- Sparse requests with ptr=2: req=1001 → gnt=1000, then ptr=0 → gnt=0001. Verifies round-robin wrap of the pointer.
- hold: with req=0011, assert hold for 3 cycles. Required: gnt=0, code frozen. On release, grants resume at the stored ptr with the next code in sequence.
- clear mid-lap (code=12, lap_cnt=3) with req=1111 and hold=1: no grant, then code=8, ptr=0, lap_cnt=0. The next grant goes to req[0] with code 8.

Source files
------------

// File: rtl/seq_code_arbiter.sv
// Purpose : round-robin arbiter handing out one shared 14-code scrambled sequence, one code per grant.
// Latency : 0 cycles from req to gnt/code_valid; code, ptr and lap_cnt advance on the edge after a grant.
// Backpressure: hold or clear suppress all grants; a requester keeps req high until it is granted.
//
// Ports:
//   clk, reset      - clock; asynchronous active-high reset
//   clear           - synchronous restart (code=SEED, ptr=0, lap_cnt=0), beats hold and req
//   hold            - freeze: no grants, no state change
//   req[NREQ]       - level-sensitive token requests
//   gnt[NREQ]       - one-hot/zero grant, combinational
//   code[4]         - current sequence code (registered), valid to grantee when code_valid
//   code_valid      - OR of gnt
//   wrap            - code 13 (last of lap) is being issued this cycle
//   lap_cnt[8]      - completed laps, modulo 256
module seq_code_arbiter #(
  parameter int         NREQ = 4,
  parameter logic [3:0] SEED = 4'd8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            hold,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [3:0]      code,
  output logic            code_valid,
  output logic            wrap,
  output logic [7:0]      lap_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;

  // Scrambled 14-state sequence; non-members (0, 10) fall back to the lap start.
  function automatic logic [3:0] next_code(input logic [3:0] c);
    case (c)
      4'd8:    next_code = 4'd7;
      4'd7:    next_code = 4'd11;
      4'd11:   next_code = 4'd4;
      4'd4:    next_code = 4'd9;
      4'd9:    next_code = 4'd2;
      4'd2:    next_code = 4'd5;
      4'd5:    next_code = 4'd12;
      4'd12:   next_code = 4'd6;
      4'd6:    next_code = 4'd3;
      4'd3:    next_code = 4'd15;
      4'd15:   next_code = 4'd1;
      4'd1:    next_code = 4'd14;
      4'd14:   next_code = 4'd13;
      4'd13:   next_code = 4'd8;
      default: next_code = 4'd8;
    endcase
  endfunction

  // Search starts at ptr and wraps; the first asserted request wins.
  // reset is included so gnt drops the moment reset asserts, not at the next edge.
  always_comb begin : grant_search
    logic          found;
    logic [PW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (!(reset || clear || hold)) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = PW'((int'(ptr) + k) % NREQ);
        if (!found && req[idx]) begin
          found      = 1'b1;
          gnt[idx]   = 1'b1;
          gnt_idx    = idx;
        end
      end
    end
  end

  assign code_valid = |gnt;
  assign wrap       = code_valid && (code == 4'd13);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code    <= SEED;
      ptr     <= '0;
      lap_cnt <= 8'd0;
    end else if (clear) begin
      code    <= SEED;
      ptr     <= '0;
      lap_cnt <= 8'd0;
    end else if (code_valid) begin
      // code_valid is already low under hold, so no separate hold term is needed here.
      code <= next_code(code);
      if (gnt_idx == PW'(NREQ - 1))
        ptr <= '0;
      else
        ptr <= gnt_idx + 1'b1;
      if (wrap)
        lap_cnt <= lap_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_seq_code_arbiter.sv
// Directed bench for seq_code_arbiter (NREQ=4, SEED=8): reset, single/multi requester,
// pointer wrap, hold, clear and lap counter rollover, against hand-computed expectations.
module tb_seq_code_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       hold;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] code;
  logic       code_valid;
  logic       wrap;
  logic [7:0] lap_cnt;

  int errors = 0;
  int checks = 0;

  int seq_tab [15] = '{8, 7, 11, 4, 9, 2, 5, 12, 6, 3, 15, 1, 14, 13, 8};
  int rr_gnt  [5]  = '{1, 2, 4, 8, 1};
  int rr_code [5]  = '{8, 7, 11, 4, 9};

  seq_code_arbiter #(.NREQ(4), .SEED(4'd8)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .hold       (hold),
    .req        (req),
    .gnt        (gnt),
    .code       (code),
    .code_valid (code_valid),
    .wrap       (wrap),
    .lap_cnt    (lap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    hold  = 1'b0;
    req   = 4'b0000;
    #3;
    chk("rst_code",  32'(code), 8);
    chk("rst_gnt",   32'(gnt), 0);
    chk("rst_valid", 32'(code_valid), 0);
    chk("rst_wrap",  32'(wrap), 0);
    chk("rst_lap",   32'(lap_cnt), 0);
    tick;
    reset = 1'b0;

    // Five grants to req[0], then reset mid-grant.
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("pre_gnt",  32'(gnt), 1);
      chk("pre_code", 32'(code), 32'(seq_tab[i]));
      tick;
    end
    reset = 1'b1;
    #1;
    chk("arst_code",  32'(code), 8);
    chk("arst_gnt",   32'(gnt), 0);
    chk("arst_valid", 32'(code_valid), 0);
    chk("arst_lap",   32'(lap_cnt), 0);
    reset = 1'b0;

    // Lone requester: 15 back-to-back grants, wrap on the 14th.
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("solo_gnt",  32'(gnt), 1);
      chk("solo_code", 32'(code), 32'(seq_tab[i]));
      chk("solo_wrap", 32'(wrap), 32'(i == 13));
      tick;
    end
    chk("solo_lap",  32'(lap_cnt), 1);
    chk("solo_next", 32'(code), 7);

    // All four requesting from reset: strict rotation.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gnt",  32'(gnt), 32'(rr_gnt[i]));
      chk("rr_code", 32'(code), 32'(rr_code[i]));
      tick;
    end
    // ptr=1, code=2. One grant to req[1] moves ptr to 2.
    req = 4'b0010;
    #1;
    chk("pos_gnt",  32'(gnt), 2);
    chk("pos_code", 32'(code), 2);
    tick;
    // ptr=2, req=1001: req[3] first, then pointer wraps to req[0].
    req = 4'b1001;
    #1;
    chk("sparse_gnt3", 32'(gnt), 8);
    chk("sparse_c3",   32'(code), 5);
    tick;
    #1;
    chk("sparse_gnt0", 32'(gnt), 1);
    chk("sparse_c0",   32'(code), 12);
    tick;

    // ptr=1, code=6. Hold for three cycles with req=0011.
    req  = 4'b0011;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_gnt",   32'(gnt), 0);
      chk("hold_valid", 32'(code_valid), 0);
      chk("hold_code",  32'(code), 6);
      tick;
    end
    hold = 1'b0;
    #1;
    chk("unhold_gnt",  32'(gnt), 2);
    chk("unhold_code", 32'(code), 6);
    tick;
    #1;
    chk("unhold_gnt2",  32'(gnt), 1);
    chk("unhold_code2", 32'(code), 3);
    tick;

    // Build up to code=12, lap_cnt=3: 42 grants (3 laps) + 7 more.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 49; i++) tick;
    req = 4'b0000;
    #1;
    chk("mid_lap",  32'(lap_cnt), 3);
    chk("mid_code", 32'(code), 12);

    // clear + hold + req=1111: clear wins, then restart at req[0] with code 8.
    req   = 4'b1111;
    hold  = 1'b1;
    clear = 1'b1;
    #1;
    chk("clr_gnt",   32'(gnt), 0);
    chk("clr_valid", 32'(code_valid), 0);
    tick;
    chk("clr_code", 32'(code), 8);
    chk("clr_lap",  32'(lap_cnt), 0);
    clear = 1'b0;
    hold  = 1'b0;
    #1;
    chk("post_clr_gnt",  32'(gnt), 1);
    chk("post_clr_code", 32'(code), 8);

    // Lap counter rollover: 255 laps, then one more wraps to 0.
    req = 4'b0001;
    for (int i = 0; i < 14 * 255; i++) tick;
    chk("lap_255", 32'(lap_cnt), 255);
    for (int i = 0; i < 14; i++) tick;
    chk("lap_wrap0", 32'(lap_cnt), 0);
    chk("lap_code",  32'(code), 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
